// File: rtl/ddr_pad_deserializer.sv
// ddr_pad_deserializer: assembles iCE40 DDR pad bit pairs into aligned words behind a one-word holding register
module ddr_pad_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_0,
    input  logic             din_1,
    input  logic             cap_en,
    input  logic             align,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    input  logic             ready,
    output logic             overrun,
    output logic             locked
);
    localparam int PAIRS = WIDTH / 2;
    localparam int CW = PAIRS > 1 ? $clog2(PAIRS) : 1;
    typedef enum logic {UNLOCKED, SHIFT} state_t;
    state_t state, state_nxt;
    logic [WIDTH-1:0] sr, sr_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic take, last, complete;
    always_comb begin
        take = cap_en && (state == SHIFT || align);
        last = cnt == CW'(PAIRS - 1);
        complete = take && (align ? PAIRS == 1 : last);
        sr_nxt = !take ? sr : align ? WIDTH'({din_0, din_1}) : WIDTH'({sr, din_0, din_1});
        cnt_nxt = !take ? cnt : align ? CW'(PAIRS > 1) : last ? '0 : cnt + 1'b1;
        state_nxt = take ? SHIFT : state;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= UNLOCKED;
        else state <= state_nxt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
            cnt <= '0;
            data_out <= '0;
            valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            sr <= sr_nxt;
            cnt <= cnt_nxt;
            if (complete && (!valid || ready)) begin
                data_out <= sr_nxt;
                valid <= 1'b1;
            end else if (valid && ready) valid <= 1'b0;
            if (complete && valid && !ready) overrun <= 1'b1;
            else if (clr_ovr) overrun <= 1'b0;
        end
    end
    assign locked = state == SHIFT;
endmodule

// File: doc/ddr_pad_deserializer.md
Name: ddr_pad_deserializer

Overview:
- Consumes the two registered samples from an iCE40 DDR input pad: din_0, the rising-edge sample, and din_1, the falling-edge sample.
- Assembles the samples into WIDTH-bit parallel words and delivers them on a valid/ready interface with a one-word holding register.
- Sits between the pad cell and the capture logic, for example a keyboard or parallel-bus receiver.
- It is the input/reader end of the pad: the pad cell produces the bit pairs, this block turns them into words.

Parameters:
WIDTH, 8, word width in bits; must be even and ≥2; WIDTH/2 bit pairs per word.

Ports:
clk  input  1  system clock; also the pad INPUT_CLK.
rst  input  1  asynchronous reset, active-high.
din_0  input  1  pad rising-edge sample (D_IN_0); the older bit of each pair.
din_1  input  1  pad falling-edge sample (D_IN_1); the newer bit of each pair.
cap_en  input  1  pair-valid qualifier; no pair is taken when low.
align  input  1  when high with cap_en, the current pair is the first pair of a new word.
clr_ovr  input  1  synchronous clear of overrun.
data_out  output  WIDTH  held word, MSB = first bit received.
valid  output  1  data_out holds an undelivered word.
ready  input  1  consumer accepts data_out when valid && ready.
overrun  output  1  sticky flag: a completed word was dropped.
locked  output  1  word alignment established.

Behaviour:
- Reset (async, rst=1):
  - data_out=0, valid=0, overrun=0, locked=0.
  - Shift register and pair counter cnt are cleared to 0.
  - Reset mid-word or with valid high discards everything.
- Bit order:
  - Each accepted pair shifts in two bits: din_0 first, then din_1.
  - The first bit received after align lands in data_out[WIDTH-1].
- States: UNLOCKED (locked=0), SHIFT (locked=1).
- UNLOCKED:
  - Pairs with cap_en=1, align=0 are discarded.
  - cap_en=1, align=1: pair loaded as pair 0, cnt←1, go to SHIFT.
- SHIFT:
  - cap_en=0: shift register and cnt hold.
  - cap_en=1, align=0: shift in the pair, cnt←cnt+1.
  - cap_en=1, align=1: partial word discarded; pair loaded as pair 0, cnt←1. There is no overrun and no output for the partial word.
- Word completion:
  - Completion occurs on the edge that accepts pair WIDTH/2-1; cnt wraps to 0.
  - Completion together with align in the same pair: align wins, the word is not completed.
  - WIDTH=2 special case: every accepted pair completes a word; the align pair itself completes one.
- Holding register:
  - On completion, if valid=0 or (valid && ready): data_out←assembled word, valid←1.
  - Latency: the last pair is accepted at edge k; data_out/valid are visible after edge k (one clock).
  - On completion with valid=1 and ready=0: the new word is dropped, data_out is unchanged, overrun←1.
  - valid && ready with no completion: valid←0, data_out holds its old value.
- Words arrive back-to-back at most every WIDTH/2 cycles. For WIDTH=2, a completion every cycle with ready held high is lossless.
- overrun:
  - Sticky until rst or clr_ovr.
  - clr_ovr in the same cycle as a new drop: overrun stays 1 (set wins).
- locked stays 1 until rst; align never clears it.

Test Plan:
1. WIDTH=8, rst, then cap_en=1 with pairs (din_0,din_1) = (1,0)[align=1], (1,0), (0,1), (1,1), ready=1:
   - data_out=0xA7 and valid=1 one clock after the 4th pair.
   - valid drops on the following edge.
   - locked=1 from the edge after the first pair.
2. Before any align, feed 6 pairs of (1,1); then align and send (0,0)×4:
   - The first 6 pairs produce no output; locked stays 0 until the align pair.
   - The word is 0x00.
3. Align, send (1,1)×2, then align with (0,1), (0,0)×3:
   - The partial word is discarded.
   - The word is 0x40; no overrun.
4. ready=0; send two complete words 0x5A then 0xC3:
   - data_out stays 0x5A and valid=1.
   - overrun=1 one clock after the 2nd word completes.
   - Pulse clr_ovr → overrun=0.
5. Holding 0x5A, assert ready on the same edge 0x3C completes:
   - data_out=0x3C, valid stays 1, overrun=0.
6. Align, send 2 pairs with cap_en toggling low between them, then assert rst mid-word:
   - The pair counter holds while cap_en=0.
   - After rst: valid=0, locked=0, data_out=0.
   - A subsequent align restarts cleanly.
